// File: rtl/aq_djpeg_coef_buffer_pkg.sv
// Shared JPEG decoder definitions.
// Holds the block size, the zigzag-to-raster table and the zz2raster() lookup helper.
package aq_djpeg_pkg;

  localparam int unsigned AQ_DJPEG_BLK   = 64;
  localparam int unsigned AQ_DJPEG_IDX_W = 6;

  // Raster position of the n-th coefficient in zigzag scan order.
  localparam logic [5:0] ZIGZAG [AQ_DJPEG_BLK] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz2raster(input logic [5:0] idx);
    return ZIGZAG[idx];
  endfunction

endpackage

// File: rtl/aq_djpeg_coef_buffer_if.sv
// Coefficient buffer bus: write side from the Huffman decoder, read side to the iDCT.
// master = decoder/iDCT side (drives strobes, data, addresses);
// slave  = buffer (drives Ready, OverflowErr, OutEnable, OutColor, DataOutA/B).
interface aq_djpeg_coef_buffer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COMP_W = 3
);
  logic              DataInit;
  logic              DataInEnable;
  logic [5:0]        DataInAddress;
  logic [COMP_W-1:0] DataInColor;
  logic [DATA_W-1:0] DataIn;
  logic              HuffmanEndEnable;
  logic              DataInReady;
  logic              OverflowErr;
  logic              DataOutEnable;
  logic [COMP_W-1:0] DataOutColor;
  logic [4:0]        DataOutAddress;
  logic              DataOutRead;
  logic [DATA_W-1:0] DataOutA;
  logic [DATA_W-1:0] DataOutB;

  modport master (
    output DataInit, DataInEnable, DataInAddress, DataInColor, DataIn,
           HuffmanEndEnable, DataOutAddress, DataOutRead,
    input  DataInReady, OverflowErr, DataOutEnable, DataOutColor, DataOutA, DataOutB
  );

  modport slave (
    input  DataInit, DataInEnable, DataInAddress, DataInColor, DataIn,
           HuffmanEndEnable, DataOutAddress, DataOutRead,
    output DataInReady, OverflowErr, DataOutEnable, DataOutColor, DataOutA, DataOutB
  );
endinterface

// File: rtl/aq_djpeg_coef_buffer_zigzag_lut.sv
// Combinational coefficient index map: zigzag -> raster, or identity when bypassed.
// Ports: idx (incoming coefficient index), raster_c (raster position).
module aq_djpeg_zigzag_lut
  import aq_djpeg_pkg::*;
#(
  parameter bit ZIGZAG_EN = 1'b1
) (
  input  logic [5:0] idx,
  output logic [5:0] raster_c
);

  assign raster_c = ZIGZAG_EN ? zz2raster(idx) : idx;

endmodule

// File: rtl/aq_djpeg_coef_buffer.sv
// Multi-bank 8x8 coefficient buffer between the Huffman decoder and the iDCT.
// Sparse coefficients are written in raster order into the current write bank,
// committed blocks are queued FIFO-style and read out as coefficient pairs.
// Ports: clk, rst (async, active-low), bus (slave side of aq_djpeg_coef_buffer_if).
module aq_djpeg_coef_buffer
  import aq_djpeg_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned COMP_W    = 3,
  parameter bit          ZIGZAG_EN = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  aq_djpeg_coef_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_BANKS);
  localparam int unsigned CNT_W = $clog2(NUM_BANKS + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BANKS);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt_c, rd_ptr_nxt_c;
  logic [CNT_W-1:0]  count, count_nxt_c;
  logic [5:0]        raster_addr_c, idx_a_c, idx_b_c;
  logic              wr_acc_c, commit_acc_c, release_c, overflow_c;
  logic [DATA_W-1:0] rd_a_c [NUM_BANKS];
  logic [DATA_W-1:0] rd_b_c [NUM_BANKS];
  logic [COMP_W-1:0] tag_nxt_c [NUM_BANKS];

  aq_djpeg_zigzag_lut #(.ZIGZAG_EN(ZIGZAG_EN)) u_zigzag_lut (
    .idx      (bus.DataInAddress),
    .raster_c (raster_addr_c)
  );

  assign idx_a_c   = {bus.DataOutAddress, 1'b0};
  assign idx_b_c   = {bus.DataOutAddress, 1'b1};
  assign wr_acc_c  = bus.DataInEnable & bus.DataInReady;
  assign release_c = bus.DataOutRead & bus.DataOutEnable;
  // A full buffer still takes a commit when the head is released in the same cycle.
  assign commit_acc_c = bus.HuffmanEndEnable & (bus.DataInReady | release_c);
  assign overflow_c   = (bus.DataInEnable & ~bus.DataInReady) |
                        (bus.HuffmanEndEnable & ~commit_acc_c);

  // Next pointer / occupancy.
  always_comb begin
    wr_ptr_nxt_c = wr_ptr;
    rd_ptr_nxt_c = rd_ptr;
    count_nxt_c  = count;
    if (commit_acc_c) wr_ptr_nxt_c = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
    if (release_c)    rd_ptr_nxt_c = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
    if (commit_acc_c && !release_c)      count_nxt_c = count + CNT_W'(1);
    else if (!commit_acc_c && release_c) count_nxt_c = count - CNT_W'(1);
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0]       mem [AQ_DJPEG_BLK];
    logic [AQ_DJPEG_BLK-1:0] mask;
    logic [COMP_W-1:0]       tag;
    logic                    wr_sel_c, rd_sel_c, wr_hit_c;

    assign wr_sel_c = (wr_ptr == PTR_W'(b));
    assign rd_sel_c = (rd_ptr == PTR_W'(b));
    assign wr_hit_c = wr_acc_c & wr_sel_c;

    // Payload has no reset; the valid mask decides what reads back as data.
    always_ff @(posedge clk) begin
      if (wr_hit_c) mem[raster_addr_c] <= bus.DataIn;
    end

    // Mask clears on release, so whichever bank opens next starts empty.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mask <= '0;
        tag  <= '0;
      end else if (bus.DataInit) begin
        mask <= '0;
        tag  <= '0;
      end else begin
        if (release_c && rd_sel_c) mask <= '0;
        else if (wr_hit_c)         mask[raster_addr_c] <= 1'b1;
        tag <= tag_nxt_c[b];
      end
    end

    assign tag_nxt_c[b] = ((wr_acc_c || commit_acc_c) && wr_sel_c) ? bus.DataInColor : tag;

    // Bypass the in-flight write so a block that becomes head this cycle reads complete.
    assign rd_a_c[b] = (wr_hit_c && raster_addr_c == idx_a_c) ? bus.DataIn :
                       (mask[idx_a_c] ? mem[idx_a_c] : '0);
    assign rd_b_c[b] = (wr_hit_c && raster_addr_c == idx_b_c) ? bus.DataIn :
                       (mask[idx_b_c] ? mem[idx_b_c] : '0);
  end

  // Control and read-port registers; outputs follow the post-edge head bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      bus.DataInReady   <= 1'b1;
      bus.OverflowErr   <= 1'b0;
      bus.DataOutEnable <= 1'b0;
      bus.DataOutColor  <= '0;
      bus.DataOutA      <= '0;
      bus.DataOutB      <= '0;
    end else if (bus.DataInit) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      bus.DataInReady   <= 1'b1;
      bus.OverflowErr   <= 1'b0;
      bus.DataOutEnable <= 1'b0;
      bus.DataOutColor  <= '0;
      bus.DataOutA      <= '0;
      bus.DataOutB      <= '0;
    end else begin
      wr_ptr            <= wr_ptr_nxt_c;
      rd_ptr            <= rd_ptr_nxt_c;
      count             <= count_nxt_c;
      bus.DataInReady   <= (count_nxt_c < CNT_FULL);
      bus.OverflowErr   <= bus.OverflowErr | overflow_c;
      bus.DataOutEnable <= (count_nxt_c != '0);
      bus.DataOutColor  <= tag_nxt_c[rd_ptr_nxt_c];
      bus.DataOutA      <= (count_nxt_c != '0) ? rd_a_c[rd_ptr_nxt_c] : '0;
      bus.DataOutB      <= (count_nxt_c != '0) ? rd_b_c[rd_ptr_nxt_c] : '0;
    end
  end

endmodule

// File: tb/tb_aq_djpeg_coef_buffer.sv
// Self-checking bench for aq_djpeg_coef_buffer.
// dut0: NUM_BANKS=2, zigzag on. dut1: NUM_BANKS=3, zigzag bypassed.
// A block-level FIFO model (flat data queue + tag queue) supplies expected values.
`timescale 1ns/1ps
module tb_aq_djpeg_coef_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aq_djpeg_coef_buffer_if #(.DATA_W(16), .COMP_W(3)) bus0 ();
  aq_djpeg_coef_buffer_if #(.DATA_W(16), .COMP_W(3)) bus1 ();

  aq_djpeg_coef_buffer #(.DATA_W(16), .NUM_BANKS(2), .COMP_W(3), .ZIGZAG_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  aq_djpeg_coef_buffer #(.DATA_W(16), .NUM_BANKS(3), .COMP_W(3), .ZIGZAG_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Shared stimulus; strobes are routed only to the selected DUT.
  logic        sel = 1'b0;
  logic        d_init = 1'b0, d_en = 1'b0, d_end = 1'b0, d_rd = 1'b0;
  logic [5:0]  d_addr = '0;
  logic [2:0]  d_col = '0;
  logic [15:0] d_in = '0;
  logic [4:0]  d_oaddr = '0;

  assign bus0.DataInit         = d_init & ~sel;
  assign bus0.DataInEnable     = d_en & ~sel;
  assign bus0.HuffmanEndEnable = d_end & ~sel;
  assign bus0.DataOutRead      = d_rd & ~sel;
  assign bus0.DataInAddress    = d_addr;
  assign bus0.DataInColor      = d_col;
  assign bus0.DataIn           = d_in;
  assign bus0.DataOutAddress   = d_oaddr;
  assign bus1.DataInit         = d_init & sel;
  assign bus1.DataInEnable     = d_en & sel;
  assign bus1.HuffmanEndEnable = d_end & sel;
  assign bus1.DataOutRead      = d_rd & sel;
  assign bus1.DataInAddress    = d_addr;
  assign bus1.DataInColor      = d_col;
  assign bus1.DataIn           = d_in;
  assign bus1.DataOutAddress   = d_oaddr;

  logic        o_ready, o_ovf, o_en;
  logic [2:0]  o_col;
  logic [15:0] o_a, o_b;
  always_comb begin
    o_ready = sel ? bus1.DataInReady   : bus0.DataInReady;
    o_ovf   = sel ? bus1.OverflowErr   : bus0.OverflowErr;
    o_en    = sel ? bus1.DataOutEnable : bus0.DataOutEnable;
    o_col   = sel ? bus1.DataOutColor  : bus0.DataOutColor;
    o_a     = sel ? bus1.DataOutA      : bus0.DataOutA;
    o_b     = sel ? bus1.DataOutB      : bus0.DataOutB;
  end

  int checks = 0;
  int failures = 0;

  // Reference model: open block, committed blocks (64 raster words each), tags.
  logic [15:0] m_cur [64];
  logic [15:0] m_qd [$];
  logic [2:0]  m_qt [$];
  logic        m_ovf;
  int          zz_raster [64];

  // Zigzag order derived by walking anti-diagonals of the 8x8 block.
  function automatic void build_zigzag();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_raster[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_raster[n] = r * 8 + (s - r); n++; end
      end
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_cur[i] = '0;
    m_qd.delete();
    m_qt.delete();
    m_ovf = 1'b0;
  endfunction

  // One clock of stimulus; the model advances with the same inputs.
  task automatic step(input logic we, input int idx, input logic [15:0] val,
                      input logic [2:0] col, input logic com, input logic rd,
                      input logic init);
    int  nb;
    bit  rdy, rel;
    d_en = we; d_addr = 6'(idx); d_in = val; d_col = col;
    d_end = com; d_rd = rd; d_init = init;
    @(posedge clk);
    nb = sel ? 3 : 2;
    if (init) begin
      model_clear();
    end else begin
      rdy = (m_qt.size() < nb);
      rel = rd && (m_qt.size() > 0);
      if (we) begin
        if (rdy) m_cur[sel ? idx : zz_raster[idx]] = val;
        else     m_ovf = 1'b1;
      end
      if (rel) begin
        for (int i = 0; i < 64; i++) void'(m_qd.pop_front());
        void'(m_qt.pop_front());
      end
      if (com) begin
        if (rdy || rel) begin
          for (int i = 0; i < 64; i++) begin m_qd.push_back(m_cur[i]); m_cur[i] = '0; end
          m_qt.push_back(col);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    #1;
    d_en = 1'b0; d_end = 1'b0; d_rd = 1'b0; d_init = 1'b0;
  endtask

  // Sweep all 32 pairs of the head block against the model.
  task automatic read_head_block(input string name);
    logic [15:0] ea, eb;
    for (int p = 0; p < 32; p++) begin
      d_oaddr = 5'(p);
      step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      ea = (m_qt.size() > 0) ? m_qd[2*p]   : 16'h0;
      eb = (m_qt.size() > 0) ? m_qd[2*p+1] : 16'h0;
      checks++;
      if (o_a !== ea || o_b !== eb) begin
        failures++;
        $display("FAIL %s pair=%0d got A=%h B=%h exp A=%h B=%h", name, p, o_a, o_b, ea, eb);
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    step(1'b1, 5, 16'h1234, 3'd2, 1'b0, 1'b0, 1'b0);
    d_en = 1'b1; d_addr = 6'd7; d_in = 16'h55AA;
    #2 rst = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL reset_out_enable got=%b exp=0", o_en); end
    checks++; if (o_a !== 16'h0 || o_b !== 16'h0) begin failures++; $display("FAIL reset_ab got=%h/%h exp=0/0", o_a, o_b); end
    checks++; if (o_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", o_ovf); end
    @(posedge clk); #1;
    d_en = 1'b0;
    rst = 1'b1;
    model_clear();
    step(1'b0, 0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (o_en !== 1'b1) begin failures++; $display("FAIL reset_discard_commit got=%b exp=1", o_en); end
    read_head_block("reset_discard");
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_zigzag();
    sel = 1'b0;
    step(1'b1, 2, 16'h0010, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3, 16'hFFF0, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0);
    checks++; if (o_en !== 1'b1) begin failures++; $display("FAIL zz_enable got=%b exp=1", o_en); end
    checks++; if (o_col !== 3'd1) begin failures++; $display("FAIL zz_color got=%0d exp=1", o_col); end
    d_oaddr = 5'd4;
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (o_a !== 16'h0010 || o_b !== 16'h0) begin failures++; $display("FAIL zz_pair4 got=%h/%h exp=0010/0000", o_a, o_b); end
    d_oaddr = 5'd8;
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (o_a !== 16'hFFF0 || o_b !== 16'h0) begin failures++; $display("FAIL zz_pair8 got=%h/%h exp=fff0/0000", o_a, o_b); end
    read_head_block("zz_block");
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL zz_release got=%b exp=0", o_en); end
  endtask

  task automatic test_sparse_clear();
    sel = 1'b0;
    for (int k = 0; k < 64; k++) step(1'b1, k, 16'(k), 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 16'h0, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 0, 16'd5, 3'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 16'h0, 3'd3, 1'b1, 1'b0, 1'b0);
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL sparse_full_ready got=%b exp=0", o_ready); end
    read_head_block("sparse_b1");
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    d_oaddr = 5'd0;
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (o_a !== 16'd5 || o_b !== 16'd0) begin failures++; $display("FAIL sparse_pair0 got=%h/%h exp=0005/0000", o_a, o_b); end
    read_head_block("sparse_b2");
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    // Third block reuses the bank that held the fully written block.
    step(1'b1, 63, 16'd7, 3'd4, 1'b1, 1'b0, 1'b0);
    d_oaddr = 5'd31;
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (o_a !== 16'd0 || o_b !== 16'd7) begin failures++; $display("FAIL sparse_pair31 got=%h/%h exp=0000/0007", o_a, o_b); end
    read_head_block("sparse_b3");
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_full();
    sel = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++)
        step(1'b1, int'($urandom_range(0, 63)), 16'($urandom), 3'(b), 1'b0, 1'b0, 1'b0);
      step(1'b0, 0, 16'h0, 3'(b), 1'b1, 1'b0, 1'b0);
    end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", o_ready); end
    step(1'b1, 10, 16'hDEAD, 3'd5, 1'b1, 1'b0, 1'b0);
    checks++; if (o_ovf !== 1'b1) begin failures++; $display("FAIL full_ovf got=%b exp=1", o_ovf); end
    checks++; if (o_col !== 3'd0) begin failures++; $display("FAIL full_head_color got=%0d exp=0", o_col); end
    read_head_block("full_b0");
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL full_release_ready got=%b exp=1", o_ready); end
    checks++; if (o_ovf !== 1'b1) begin failures++; $display("FAIL full_ovf_sticky got=%b exp=1", o_ovf); end
    checks++; if (o_col !== 3'd1) begin failures++; $display("FAIL full_next_color got=%0d exp=1", o_col); end
    read_head_block("full_b1");
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (o_ovf !== 1'b0 || o_ready !== 1'b1 || o_en !== 1'b0) begin
      failures++; $display("FAIL full_init got ovf=%b rdy=%b en=%b exp 0/1/0", o_ovf, o_ready, o_en);
    end
  endtask

  task automatic test_simultaneous();
    sel = 1'b0;
    for (int b = 0; b < 2; b++) begin
      step(1'b1, int'($urandom_range(0, 63)), 16'($urandom), 3'(b), 1'b1, 1'b0, 1'b0);
    end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL simul_full got=%b exp=0", o_ready); end
    step(1'b0, 0, 16'h0, 3'd2, 1'b1, 1'b1, 1'b0);
    checks++; if (o_en !== 1'b1 || o_ready !== 1'b0) begin
      failures++; $display("FAIL simul_count got en=%b rdy=%b exp 1/0", o_en, o_ready);
    end
    checks++; if (o_ovf !== 1'b0) begin failures++; $display("FAIL simul_ovf got=%b exp=0", o_ovf); end
    checks++; if (o_col !== 3'd1) begin failures++; $display("FAIL simul_tag1 got=%0d exp=1", o_col); end
    read_head_block("simul_b1");
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (o_col !== 3'd2) begin failures++; $display("FAIL simul_tag2 got=%0d exp=2", o_col); end
    read_head_block("simul_b2");
    step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL simul_empty got=%b exp=0", o_en); end
  endtask

  task automatic test_wrap();
    int produced, consumed, wl;
    sel = 1'b1;
    model_clear();
    produced = 0; consumed = 0;
    wl = int'($urandom_range(0, 6));
    for (int it = 0; it < 3000 && consumed < 7; it++) begin
      if (m_qt.size() > 0 && ($urandom_range(0, 3) == 0 || produced == 7)) begin
        checks++;
        if (o_col !== 3'(consumed)) begin failures++; $display("FAIL wrap_tag got=%0d exp=%0d", o_col, consumed); end
        read_head_block("wrap_block");
        step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        consumed++;
      end else if (produced < 7 && m_qt.size() < 3) begin
        if (wl > 0) begin
          step(1'b1, int'($urandom_range(0, 63)), 16'($urandom), 3'(produced), 1'b0, 1'b0, 1'b0);
          wl--;
        end else begin
          step(1'b0, 0, 16'h0, 3'(produced), 1'b1, 1'b0, 1'b0);
          produced++;
          wl = int'($urandom_range(0, 6));
        end
        checks++;
        if (o_ready !== (m_qt.size() < 3)) begin
          failures++; $display("FAIL wrap_ready got=%b exp=%b", o_ready, (m_qt.size() < 3));
        end
      end else begin
        step(1'b0, 0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      end
    end
    checks++; if (consumed != 7) begin failures++; $display("FAIL wrap_timeout got=%0d exp=7 blocks", consumed); end
    checks++; if (o_ovf !== 1'b0 || o_en !== 1'b0) begin
      failures++; $display("FAIL wrap_end got ovf=%b en=%b exp 0/0", o_ovf, o_en);
    end
  endtask

  initial begin
    build_zigzag();
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_zigzag();
    test_sparse_clear();
    test_full();
    test_simultaneous();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
